program_loader: RTL and testbench
=================================

# program_loader

Boot-time loader that sits upstream of the processor's instruction memory. It takes a byte stream from a serial receiver over a valid/ready handshake and parses a 16-bit word-count header. It assembles big-endian 32-bit instruction words and writes them to consecutive instruction-memory addresses starting at 0. It holds the processor in reset until the load completes, and flags malformed or stalled transfers.

## Interface
- `ADDR_W`, 10, instruction-memory address width; capacity is 2^ADDR_W words.
- `TIMEOUT_CYCLES`, 100000, allowed idle cycles between accepted bytes once a load is under way; 0 disables the timeout.

- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a load; sampled in IDLE, DONE and ERROR only.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `mem_wren` output 1: instruction-memory write strobe.
- `mem_addr` output ADDR_W: write address.
- `mem_data` output 32: write data.
- `cpu_reset` output 1: processor reset request, ORed into the processor reset.
- `done` output 1: load completed successfully.
- `error` output 1: load aborted.

## Operation
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR. All outputs are registered (Moore).
- A byte is accepted on an edge where `in_valid & in_ready`. `in_ready` = 1 only in HDR_HI, HDR_LO and DATA.
- IDLE --start--> HDR_HI. DONE and ERROR --start--> HDR_HI; this clears `done` and `error` and resets the address to 0.
- HDR_HI: accepted byte becomes count[15:8], then go to HDR_LO.
- HDR_LO: accepted byte becomes count[7:0]. If count is 0 or count > 2^ADDR_W, go to ERROR; otherwise go to DATA.
- DATA: accepted bytes fill the word MSB first (first byte is [31:24]). On the 4th byte, go to WRITE.
- WRITE, one cycle:
  - `mem_wren`=1, with `mem_addr` = word index and `mem_data` = assembled word.
  - Next state is DATA, or DONE if this was word count-1.
  - The word index increments after the write.
- DONE: `cpu_reset`=0, `done`=1; `in_ready`=0.
- ERROR: `cpu_reset`=1, `error`=1, no further writes. Memory contents already written are left as they are.
- `cpu_reset`=1 in every state except DONE.
- `start` in HDR_HI, HDR_LO, DATA or WRITE is ignored. `in_valid` in IDLE, WRITE, DONE or ERROR is ignored and the byte is not consumed.
- Timeout:
  - The counter runs in HDR_LO and DATA, and clears on every accepted byte.
  - When TIMEOUT_CYCLES consecutive cycles pass without acceptance, go to ERROR.
  - HDR_HI never times out.
  - An acceptance in the same cycle as the limit wins.

## Timing
- Reset values: state IDLE, `in_ready`=0, `mem_wren`=0, `mem_addr`=0, `mem_data`=0, `cpu_reset`=1, `done`=0, `error`=0.
- Reset asserted mid-load: all outputs return to reset values on the next edge, and any partial word and header are discarded.
- Latency:
  - `mem_wren` pulses for exactly 1 cycle, in the cycle after the edge that accepted the word's 4th byte.
  - With `in_valid` held high, each word takes 5 cycles (4 accepts + WRITE).
  - `done` and `cpu_reset`=0 appear in the cycle after the last WRITE cycle.
  - `error` for a bad header appears in the cycle after the edge that accepted the low header byte.
- Wrap-around: the address never wraps, because the header check bounds count to 2^ADDR_W. The last address written is count-1 (at most 2^ADDR_W-1).

## Structure
- Shared package `loader_pkg`: state enum, `BYTES_PER_WORD`=4, `HDR_W`=16.
- Sub-module `loader_timeout` holds the idle-cycle counter. Inputs: `clk`, `reset`, `enable`, `clear`. Output: `expired`. `TIMEOUT_CYCLES`=0 ties `expired` to 0.
- The main FSM, byte-lane shift register and address counter stay in `program_loader`.

## Test plan
- Reset, `start`, stream 00 02 DE AD BE EF 01 23 45 67 with `in_valid` held high:
  - Writes addr 0 = 0xDEADBEEF and addr 1 = 0x01234567, each with a 1-cycle `mem_wren`.
  - `in_ready`=0 during both WRITE cycles.
  - `done`=1 and `cpu_reset`=0 in the cycle after the second write.
- Header 00 00: `error`=1 in the cycle after the low byte; no `mem_wren`; `cpu_reset` stays 1.
- Header 04 01 (1025, with ADDR_W=10): `error`=1 and no writes. Header 04 00 loads 1024 words; the last write is to addr 1023, then `done`=1.
- TIMEOUT_CYCLES=8: header 00 01, then 3 data bytes, then `in_valid`=0. `error` asserts 8 cycles after the 3rd acceptance and no write occurs. A repeat with the 4th byte arriving on cycle 8 completes normally.
- `reset` pulsed after 2 data bytes: outputs reach reset values on the next edge. A new `start` with 00 01 11 22 33 44 writes addr 0 = 0x11223344.
- `start` pulsed during DATA is ignored. `start` in DONE restarts the load: `done`=0 and `cpu_reset`=1 on the next edge.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_W          = 16;

  // States in which the loader is willing to take a stream byte.
  function automatic logic is_rx_state(state_t s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for the byte stream. Down-counter reloaded whenever
// the watch is off or a byte is accepted; expires at terminal count zero.
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, enable, clear};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] cnt;

      // Count idle cycles down from the limit; reload on acceptance or when not watching.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt <= LOAD;
        end else if (!enable || clear) begin
          cnt <= LOAD;
        end else if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end
      end

      // An acceptance in the limit cycle masks expiry.
      assign expired = enable & ~clear & (cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: parses a 16-bit word-count header from a byte stream,
// assembles big-endian 32-bit words and writes them to instruction memory
// from address 0, holding the processor in reset until the load completes.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start after reset
// HDR_HI    | waiting for header byte count[15:8] (no timeout)
// HDR_LO    | waiting for header byte count[7:0], then range check
// DATA      | collecting 4 bytes of the current word, MSB first
// WRITE     | one-cycle memory write of the assembled word
// DONE      | load complete, processor released
// ERROR     | bad header or stalled stream, processor held in reset
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int MAX_WORDS = 1 << ADDR_W;

  state_t             state;
  state_t             next_state;
  logic [7:0]         hdr_hi;
  logic [HDR_W-1:0]   count;
  logic [ADDR_W-1:0]  addr;
  logic [31:0]        word;
  logic [1:0]         byte_cnt;

  logic               accept;
  logic               restart;
  logic [HDR_W-1:0]   hdr_val;
  logic               hdr_bad;
  logic               last_word;
  logic               word_full;
  logic               tmo_enable;
  logic               tmo_expired;

  // in_ready is registered from the next state, so it tracks the current state.
  assign accept    = in_valid & in_ready;
  assign restart   = start & ((state == ST_IDLE) | (state == ST_DONE) | (state == ST_ERROR));
  assign hdr_val   = {hdr_hi, in_data};
  assign hdr_bad   = (hdr_val == '0) || (32'(hdr_val) > 32'(MAX_WORDS));
  assign last_word = (HDR_W'(addr) == (count - HDR_W'(1)));
  assign word_full = (byte_cnt == 2'(BYTES_PER_WORD - 1));

  assign tmo_enable = (state == ST_HDR_LO) | (state == ST_DATA);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .enable  (tmo_enable),
    .clear   (accept),
    .expired (tmo_expired)
  );

  assign mem_addr = addr;
  assign mem_data = word;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; acceptance takes priority over a timeout in the same cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (start) next_state = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        if (accept) next_state = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        if (accept)           next_state = hdr_bad ? ST_ERROR : ST_DATA;
        else if (tmo_expired) next_state = ST_ERROR;
      end
      ST_DATA: begin
        if (accept) begin
          if (word_full) next_state = ST_WRITE;
        end else if (tmo_expired) begin
          next_state = ST_ERROR;
        end
      end
      ST_WRITE: begin
        next_state = last_word ? ST_DONE : ST_DATA;
      end
      ST_DONE, ST_ERROR: begin
        if (start) next_state = ST_HDR_HI;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered Moore outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b0;
      mem_wren  <= 1'b0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      in_ready  <= is_rx_state(next_state);
      mem_wren  <= (next_state == ST_WRITE);
      cpu_reset <= (next_state != ST_DONE);
      done      <= (next_state == ST_DONE);
      error     <= (next_state == ST_ERROR);
    end
  end

  // Header capture, byte-lane shift register and word address counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_hi   <= '0;
      count    <= '0;
      addr     <= '0;
      word     <= '0;
      byte_cnt <= '0;
    end else begin
      if (restart) begin
        addr     <= '0;
        word     <= '0;
        byte_cnt <= '0;
      end
      if (state == ST_HDR_HI && accept) begin
        hdr_hi <= in_data;
      end
      if (state == ST_HDR_LO && accept) begin
        count <= hdr_val;
      end
      if (state == ST_DATA && accept) begin
        word     <= {word[23:0], in_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
      // Hold the address on the final word so it never steps past count-1.
      if (state == ST_WRITE && !last_word) begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: header table plus hand-written
// sequences for timeout, mid-load reset and start handling.
module tb_program_loader;

  localparam int ADDR_W = 10;
  localparam int TMO    = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              cpu_reset;
  logic              done;
  logic              error;

  program_loader #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_wren  (mem_wren),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    bit         exp_err;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  logic prev_wren = 1'b0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (mem_wren) begin
      check("wren_one_cycle", 32'(prev_wren), 32'd0);
      check("ready_low_in_write", 32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", mem_addr, mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("wr_data", mem_data, mon_e.data);
      end
    end
    prev_wren = mem_wren;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Present a byte and wait (bounded) for the edge that accepts it; returns at edge+1.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_byte_timeout: byte 0x%0h not accepted, in_ready=%0b required 1", b, in_ready);
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_done_next();
    @(posedge clk);
    #1;
    check("done_after_last_write", 32'(done), 32'd1);
    check("cpu_released", 32'(cpu_reset), 32'd0);
    check("no_error_on_success", 32'(error), 32'd0);
    check("ready_low_in_done", 32'(in_ready), 32'd0);
    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_mem_wren"},  32'(mem_wren),  32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_data"},  mem_data,       32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_error"},     32'(error),     32'd0);
  endtask

  initial begin
    int nw;
    logic [31:0] d;

    vecs[0] = '{hi: 8'h00, lo: 8'h02, exp_err: 1'b0};
    vecs[1] = '{hi: 8'h00, lo: 8'h00, exp_err: 1'b1};
    vecs[2] = '{hi: 8'h04, lo: 8'h01, exp_err: 1'b1};
    vecs[3] = '{hi: 8'hFF, lo: 8'hFF, exp_err: 1'b1};
    vecs[4] = '{hi: 8'h00, lo: 8'h01, exp_err: 1'b0};
    vecs[5] = '{hi: 8'h04, lo: 8'h00, exp_err: 1'b0};

    reset    = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // Bytes offered in IDLE are not taken.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    check("idle_not_ready", 32'(in_ready), 32'd0);

    // Basic two-word load with in_valid held high.
    pulse_start();
    check("hdr_hi_ready", 32'(in_ready), 32'd1);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(10'd0, 32'hDEADBEEF);
    send_word(10'd1, 32'h01234567);
    check("last_write_strobe", 32'(mem_wren), 32'd1);
    check("last_write_addr", 32'(mem_addr), 32'd1);
    check("cpu_held_in_write", 32'(cpu_reset), 32'd1);
    check_done_next();
    in_valid = 1'b0;

    // Header table: range check and full loads with random data.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b0;
      pulse_start();
      check("restart_clears_done", 32'(done), 32'd0);
      check("restart_clears_error", 32'(error), 32'd0);
      send_byte(vecs[i].hi);
      send_byte(vecs[i].lo);
      nw = int'({vecs[i].hi, vecs[i].lo});
      if (vecs[i].exp_err) begin
        check("hdr_error", 32'(error), 32'd1);
        check("hdr_cpu_held", 32'(cpu_reset), 32'd1);
        check("hdr_not_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hdr_error_holds", 32'(error), 32'd1);
      end else begin
        for (int w = 0; w < nw; w++) begin
          d = $urandom();
          send_word(ADDR_W'(w), d);
        end
        check("table_last_addr", 32'(mem_addr), 32'(nw - 1));
        check_done_next();
      end
    end
    in_valid = 1'b0;

    // Stall after 3 data bytes: error exactly TMO cycles after the 3rd acceptance.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    in_valid = 1'b0;
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("tmo_not_early", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_cpu_held", 32'(cpu_reset), 32'd1);

    // Same stall, 4th byte accepted in the limit cycle: load completes.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hB1);
    send_byte(8'hB2);
    send_byte(8'hB3);
    in_valid = 1'b0;
    repeat (TMO - 1) @(posedge clk);
    #1;
    mon_e.addr = 10'd0;
    mon_e.data = 32'hB1B2B3B4;
    exp_q.push_back(mon_e);
    in_data  = 8'hB4;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("tmo_race_write", 32'(mem_wren), 32'd1);
    check("tmo_race_no_error", 32'(error), 32'd0);
    check_done_next();

    // Reset in the middle of a word discards header and partial data.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'hC1);
    send_byte(8'hC2);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_values("midreset");
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(10'd0, 32'h11223344);
    check_done_next();
    in_valid = 1'b0;

    // Start during DATA is ignored; start in DONE restarts.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    mon_e.addr = 10'd0;
    mon_e.data = 32'h5566_7788;
    exp_q.push_back(mon_e);
    send_byte(8'h55);
    send_byte(8'h66);
    in_valid = 1'b0;
    pulse_start();
    check("start_ignored_ready", 32'(in_ready), 32'd1);
    send_byte(8'h77);
    send_byte(8'h88);
    send_word(10'd1, 32'h99AABBCC);
    check_done_next();
    in_valid = 1'b0;
    pulse_start();
    check("done_restart_done", 32'(done), 32'd0);
    check("done_restart_cpu", 32'(cpu_reset), 32'd1);
    check("done_restart_ready", 32'(in_ready), 32'd1);
    check("done_restart_addr", 32'(mem_addr), 32'd0);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
